// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall detection and a multi-cycle
// mult/div hold. Presents registered operands and control to EX and the
// forwarding unit, and produces PC/IF-ID write enables and the EX hold flag.
module id_ex_stage #(
    parameter int DATA_W     = 32,
    parameter int ALUOP_W    = 4,
    parameter int MD_LATENCY = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [4:0]         IF_ID_rs,
    input  logic [4:0]         IF_ID_rt,
    input  logic [4:0]         IF_ID_rd,
    input  logic               ID_Uses_Rt,
    input  logic [DATA_W-1:0]  ID_Read_Data1,
    input  logic [DATA_W-1:0]  ID_Read_Data2,
    input  logic [DATA_W-1:0]  ID_Imm,
    input  logic               ID_Reg_Write,
    input  logic               ID_Mem_Read,
    input  logic               ID_Mem_Write,
    input  logic               ID_Mem_To_Reg,
    input  logic               ID_ALU_Src,
    input  logic               ID_Reg_Dst,
    input  logic               ID_Mult_Div,
    input  logic [ALUOP_W-1:0] ID_ALU_Op,
    input  logic               Flush,
    output logic [4:0]         ID_EX_rs,
    output logic [4:0]         ID_EX_rt,
    output logic [4:0]         ID_EX_dest,
    output logic [DATA_W-1:0]  ID_EX_Read_Data1,
    output logic [DATA_W-1:0]  ID_EX_Read_Data2,
    output logic [DATA_W-1:0]  ID_EX_Imm,
    output logic               ID_EX_Reg_Write,
    output logic               ID_EX_Mem_Read,
    output logic               ID_EX_Mem_Write,
    output logic               ID_EX_Mem_To_Reg,
    output logic               ID_EX_ALU_Src,
    output logic               ID_EX_Mult_Div,
    output logic [ALUOP_W-1:0] ID_EX_ALU_Op,
    output logic               PC_Write,
    output logic               IF_ID_Write,
    output logic               EX_Hold
);

    // A mult/div sits in EX for MD_LATENCY cycles; the capture cycle is the
    // first, so the counter covers the remaining MD_LATENCY-1 hold cycles.
    localparam logic [3:0] MD_CNT_INIT = 4'(MD_LATENCY - 1);

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } state_t;

    state_t     state, state_nx;
    logic [3:0] md_cnt, md_cnt_nx;
    logic       load_use;
    logic       capture;
    logic       bubble;

    // Load in EX whose destination is a source of the instruction in ID.
    // Register 0 is never a real dependency, and a bubble has Mem_Read=0,
    // so each load-use pair stalls exactly once.
    always_comb begin
        load_use = ID_EX_Mem_Read && (ID_EX_dest != 5'd0) &&
                   ((ID_EX_dest == IF_ID_rs) ||
                    (ID_Uses_Rt && (ID_EX_dest == IF_ID_rt)));
    end

    // Per-cycle decision: Flush beats the mult/div hold, which beats the
    // load-use stall, which beats normal advance.
    always_comb begin
        state_nx    = state;
        md_cnt_nx   = md_cnt;
        capture     = 1'b0;
        bubble      = 1'b0;
        PC_Write    = 1'b1;
        IF_ID_Write = 1'b1;
        EX_Hold     = 1'b0;
        if (Flush) begin
            bubble    = 1'b1;
            state_nx  = RUN;
            md_cnt_nx = 4'd0;
        end else if (state == MD_BUSY) begin
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            EX_Hold     = 1'b1;
            md_cnt_nx   = md_cnt - 4'd1;
            if (md_cnt == 4'd1) begin
                state_nx = RUN;
            end
        end else if (load_use) begin
            bubble      = 1'b1;
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
        end else begin
            capture = 1'b1;
            if (ID_Mult_Div) begin
                md_cnt_nx = MD_CNT_INIT;
                state_nx  = MD_BUSY;
            end
        end
    end

    // FSM state and mult/div countdown.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= RUN;
            md_cnt <= 4'd0;
        end else begin
            state  <= state_nx;
            md_cnt <= md_cnt_nx;
        end
    end

    // ID/EX register: load a bubble, capture ID, or hold (mult/div busy).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ID_EX_rs         <= '0;
            ID_EX_rt         <= '0;
            ID_EX_dest       <= '0;
            ID_EX_Read_Data1 <= '0;
            ID_EX_Read_Data2 <= '0;
            ID_EX_Imm        <= '0;
            ID_EX_Reg_Write  <= 1'b0;
            ID_EX_Mem_Read   <= 1'b0;
            ID_EX_Mem_Write  <= 1'b0;
            ID_EX_Mem_To_Reg <= 1'b0;
            ID_EX_ALU_Src    <= 1'b0;
            ID_EX_Mult_Div   <= 1'b0;
            ID_EX_ALU_Op     <= '0;
        end else if (bubble) begin
            ID_EX_rs         <= '0;
            ID_EX_rt         <= '0;
            ID_EX_dest       <= '0;
            ID_EX_Read_Data1 <= '0;
            ID_EX_Read_Data2 <= '0;
            ID_EX_Imm        <= '0;
            ID_EX_Reg_Write  <= 1'b0;
            ID_EX_Mem_Read   <= 1'b0;
            ID_EX_Mem_Write  <= 1'b0;
            ID_EX_Mem_To_Reg <= 1'b0;
            ID_EX_ALU_Src    <= 1'b0;
            ID_EX_Mult_Div   <= 1'b0;
            ID_EX_ALU_Op     <= '0;
        end else if (capture) begin
            ID_EX_rs         <= IF_ID_rs;
            ID_EX_rt         <= IF_ID_rt;
            ID_EX_dest       <= ID_Reg_Dst ? IF_ID_rd : IF_ID_rt;
            ID_EX_Read_Data1 <= ID_Read_Data1;
            ID_EX_Read_Data2 <= ID_Read_Data2;
            ID_EX_Imm        <= ID_Imm;
            ID_EX_Reg_Write  <= ID_Reg_Write;
            ID_EX_Mem_Read   <= ID_Mem_Read;
            ID_EX_Mem_Write  <= ID_Mem_Write;
            ID_EX_Mem_To_Reg <= ID_Mem_To_Reg;
            ID_EX_ALU_Src    <= ID_ALU_Src;
            ID_EX_Mult_Div   <= ID_Mult_Div;
            ID_EX_ALU_Op     <= ID_ALU_Op;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: the driver applies one ID instruction per
// cycle and pushes the expected write enables and next ID/EX contents; a
// separate monitor pops and compares them against the DUT.
module tb_id_ex_stage;

    localparam int DATA_W     = 32;
    localparam int ALUOP_W    = 4;
    localparam int MD_LATENCY = 4;

    typedef struct packed {
        logic [4:0]  rs, rt, rd;
        logic        uses_rt;
        logic [31:0] d1, d2, imm;
        logic        rw, mr, mw, m2r, alusrc, regdst, md;
        logic [3:0]  aluop;
        logic        flush;
    } in_t;

    typedef struct packed {
        logic [4:0]  rs, rt, dest;
        logic [31:0] d1, d2, imm;
        logic        rw, mr, mw, m2r, alusrc, md;
        logic [3:0]  aluop;
    } regs_t;

    typedef struct packed {
        logic  pc, ifid, hold;
        regs_t regs;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [4:0]         IF_ID_rs = '0, IF_ID_rt = '0, IF_ID_rd = '0;
    logic               ID_Uses_Rt = 1'b0;
    logic [DATA_W-1:0]  ID_Read_Data1 = '0, ID_Read_Data2 = '0, ID_Imm = '0;
    logic               ID_Reg_Write = 1'b0, ID_Mem_Read = 1'b0, ID_Mem_Write = 1'b0;
    logic               ID_Mem_To_Reg = 1'b0, ID_ALU_Src = 1'b0, ID_Reg_Dst = 1'b0;
    logic               ID_Mult_Div = 1'b0;
    logic [ALUOP_W-1:0] ID_ALU_Op = '0;
    logic               Flush = 1'b0;
    logic [4:0]         ID_EX_rs, ID_EX_rt, ID_EX_dest;
    logic [DATA_W-1:0]  ID_EX_Read_Data1, ID_EX_Read_Data2, ID_EX_Imm;
    logic               ID_EX_Reg_Write, ID_EX_Mem_Read, ID_EX_Mem_Write;
    logic               ID_EX_Mem_To_Reg, ID_EX_ALU_Src, ID_EX_Mult_Div;
    logic [ALUOP_W-1:0] ID_EX_ALU_Op;
    logic               PC_Write, IF_ID_Write, EX_Hold;

    id_ex_stage #(.DATA_W(DATA_W), .ALUOP_W(ALUOP_W), .MD_LATENCY(MD_LATENCY)) dut (
        .clk(clk), .rst_n(rst_n),
        .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt), .IF_ID_rd(IF_ID_rd),
        .ID_Uses_Rt(ID_Uses_Rt),
        .ID_Read_Data1(ID_Read_Data1), .ID_Read_Data2(ID_Read_Data2), .ID_Imm(ID_Imm),
        .ID_Reg_Write(ID_Reg_Write), .ID_Mem_Read(ID_Mem_Read), .ID_Mem_Write(ID_Mem_Write),
        .ID_Mem_To_Reg(ID_Mem_To_Reg), .ID_ALU_Src(ID_ALU_Src), .ID_Reg_Dst(ID_Reg_Dst),
        .ID_Mult_Div(ID_Mult_Div), .ID_ALU_Op(ID_ALU_Op), .Flush(Flush),
        .ID_EX_rs(ID_EX_rs), .ID_EX_rt(ID_EX_rt), .ID_EX_dest(ID_EX_dest),
        .ID_EX_Read_Data1(ID_EX_Read_Data1), .ID_EX_Read_Data2(ID_EX_Read_Data2),
        .ID_EX_Imm(ID_EX_Imm),
        .ID_EX_Reg_Write(ID_EX_Reg_Write), .ID_EX_Mem_Read(ID_EX_Mem_Read),
        .ID_EX_Mem_Write(ID_EX_Mem_Write), .ID_EX_Mem_To_Reg(ID_EX_Mem_To_Reg),
        .ID_EX_ALU_Src(ID_EX_ALU_Src), .ID_EX_Mult_Div(ID_EX_Mult_Div),
        .ID_EX_ALU_Op(ID_EX_ALU_Op),
        .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write), .EX_Hold(EX_Hold)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    exp_t  q[$];
    regs_t m = '0;     // reference model of the ID/EX contents
    int    busy = 0;   // reference model: mult/div hold cycles still owed

    regs_t dut_regs;
    assign dut_regs = {ID_EX_rs, ID_EX_rt, ID_EX_dest, ID_EX_Read_Data1,
                       ID_EX_Read_Data2, ID_EX_Imm, ID_EX_Reg_Write, ID_EX_Mem_Read,
                       ID_EX_Mem_Write, ID_EX_Mem_To_Reg, ID_EX_ALU_Src,
                       ID_EX_Mult_Div, ID_EX_ALU_Op};

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    function automatic in_t nop();
        in_t x = '0;
        x.d1 = $urandom; x.d2 = $urandom; x.imm = $urandom;
        return x;
    endfunction

    function automatic in_t alu(input logic [4:0] rs, rt, rd, input logic uses_rt);
        in_t x = nop();
        x.rs = rs; x.rt = rt; x.rd = rd; x.uses_rt = uses_rt;
        x.rw = 1'b1; x.regdst = uses_rt; x.alusrc = ~uses_rt;
        x.aluop = 4'($urandom);
        return x;
    endfunction

    function automatic in_t lw(input logic [4:0] rs, rt);
        in_t x = nop();
        x.rs = rs; x.rt = rt; x.rd = 5'($urandom);
        x.rw = 1'b1; x.mr = 1'b1; x.m2r = 1'b1; x.alusrc = 1'b1;
        return x;
    endfunction

    function automatic in_t mult(input logic [4:0] rs, rt);
        in_t x = alu(rs, rt, 5'($urandom), 1'b1);
        x.md = 1'b1;
        return x;
    endfunction

    // Drive one ID instruction for a cycle and predict its effect.
    task automatic cyc(input in_t x);
        exp_t e;
        logic lu;
        @(negedge clk);
        IF_ID_rs = x.rs; IF_ID_rt = x.rt; IF_ID_rd = x.rd; ID_Uses_Rt = x.uses_rt;
        ID_Read_Data1 = x.d1; ID_Read_Data2 = x.d2; ID_Imm = x.imm;
        ID_Reg_Write = x.rw; ID_Mem_Read = x.mr; ID_Mem_Write = x.mw;
        ID_Mem_To_Reg = x.m2r; ID_ALU_Src = x.alusrc; ID_Reg_Dst = x.regdst;
        ID_Mult_Div = x.md; ID_ALU_Op = x.aluop; Flush = x.flush;
        lu = m.mr && (m.dest != 0) &&
             ((m.dest == x.rs) || (x.uses_rt && (m.dest == x.rt)));
        if (x.flush) begin
            e.pc = 1; e.ifid = 1; e.hold = 0; m = '0; busy = 0;
        end else if (busy > 0) begin
            e.pc = 0; e.ifid = 0; e.hold = 1; busy--;
        end else if (lu) begin
            e.pc = 0; e.ifid = 0; e.hold = 0; m = '0;
        end else begin
            e.pc = 1; e.ifid = 1; e.hold = 0;
            m.rs = x.rs; m.rt = x.rt; m.dest = x.regdst ? x.rd : x.rt;
            m.d1 = x.d1; m.d2 = x.d2; m.imm = x.imm;
            m.rw = x.rw; m.mr = x.mr; m.mw = x.mw; m.m2r = x.m2r;
            m.alusrc = x.alusrc; m.md = x.md; m.aluop = x.aluop;
            if (x.md) busy = MD_LATENCY - 1;
        end
        e.regs = m;
        q.push_back(e);
    endtask

    // Monitor: enables mid-cycle, registered contents just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (q.size() == 0) continue;
            e = q[0];
            chk("enables{PC_Write,IF_ID_Write,EX_Hold}",
                {125'd0, PC_Write, IF_ID_Write, EX_Hold}, {125'd0, e.pc, e.ifid, e.hold});
            @(posedge clk);
            #1;
            chk("id_ex_contents", {7'd0, dut_regs}, {7'd0, e.regs});
            void'(q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        in_t x;
        logic [4:0] pool [4] = '{5'd0, 5'd3, 5'd8, 5'd9};

        // Reset state
        #2;
        chk("reset_contents", {7'd0, dut_regs}, 128'd0);
        chk("reset_enables", {125'd0, PC_Write, IF_ID_Write, EX_Hold}, 128'd6);
        @(negedge clk);
        rst_n = 1'b1;

        // Load-use on rs: one bubble, then add captured
        cyc(lw(5'd2, 5'd8));
        cyc(alu(5'd8, 5'd3, 5'd9, 1'b1));
        cyc(alu(5'd8, 5'd3, 5'd9, 1'b1));
        // Load to $0 never stalls
        cyc(lw(5'd2, 5'd0));
        cyc(alu(5'd0, 5'd3, 5'd9, 1'b1));
        // rt match without rt use: no stall; with rt use: one stall
        cyc(lw(5'd2, 5'd8));
        cyc(alu(5'd4, 5'd8, 5'd9, 1'b0));
        cyc(lw(5'd2, 5'd8));
        cyc(alu(5'd4, 5'd8, 5'd9, 1'b1));
        cyc(alu(5'd4, 5'd8, 5'd9, 1'b1));
        // Mult/div hold, then the next instruction
        cyc(mult(5'd3, 5'd4));
        for (int i = 0; i < 4; i++) cyc(alu(5'd5, 5'd6, 5'd7, 1'b1));
        // Flush during MD_BUSY with md_cnt=2
        cyc(mult(5'd3, 5'd4));
        cyc(nop());
        x = alu(5'd5, 5'd6, 5'd7, 1'b1); x.flush = 1'b1;
        cyc(x);
        cyc(alu(5'd5, 5'd6, 5'd7, 1'b1));
        // Flush coinciding with load-use
        cyc(lw(5'd2, 5'd8));
        x = alu(5'd8, 5'd3, 5'd9, 1'b1); x.flush = 1'b1;
        cyc(x);
        // Back-to-back independent ALU ops, alternating Reg_Dst
        for (int i = 0; i < 8; i++) begin
            x = alu(5'($urandom_range(1, 31)), 5'($urandom_range(1, 31)),
                    5'($urandom_range(1, 31)), 1'b1);
            x.regdst = i[0];
            cyc(x);
        end

        // Asynchronous reset in MD_BUSY with md_cnt=2
        cyc(mult(5'd3, 5'd4));
        cyc(nop());
        @(negedge clk);
        wait (q.size() == 0);
        #2;
        rst_n = 1'b0;
        m = '0;
        busy = 0;
        #1;
        chk("async_reset_contents", {7'd0, dut_regs}, 128'd0);
        chk("async_reset_enables", {125'd0, PC_Write, IF_ID_Write, EX_Hold}, 128'd6);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(alu(5'd5, 5'd6, 5'd7, 1'b1));

        // Randomized traffic over a small register pool to provoke hazards
        for (int i = 0; i < 400; i++) begin
            int k = $urandom_range(0, 99);
            logic [4:0] a = pool[$urandom_range(0, 3)];
            logic [4:0] b = pool[$urandom_range(0, 3)];
            logic [4:0] c = pool[$urandom_range(0, 3)];
            if (k < 30)      x = lw(a, b);
            else if (k < 40) x = mult(a, b);
            else if (k < 45) x = nop();
            else begin
                x = alu(a, b, c, 1'($urandom));
                x.regdst = 1'($urandom);
                x.mw = 1'($urandom);
            end
            x.flush = ($urandom_range(0, 11) == 0);
            cyc(x);
        end

        @(negedge clk);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
